// File: rtl/fp_mul_iter_ctrl_if.sv
// Operand/result handshake bundle for fp_mul_iter_ctrl.
// master = producer of operands / consumer of results, slave = the multiplier.
interface fp_mul_iter_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;

  modport master (output in_valid, op_a, op_b, out_ready,
                  input  in_ready, out_valid, result, flags);
  modport slave  (input  in_valid, op_a, op_b, out_ready,
                  output in_ready, out_valid, result, flags);
endinterface

// File: rtl/fp_mul_iter_ctrl.sv
// Iterative binary32 multiply controller feeding a DSP48E1 slice.
// The 24x24 significand product is built from two partial products
// (low 17 bits of mb, then high 7 bits with a 17-bit P shift-accumulate),
// then normalised, rounded and packed. One operation in flight.
// Build option: define FPMUL_RNE_EN for round-to-nearest-even; otherwise
// the result is truncated and overflow saturates to max finite.
module fp_mul_iter_ctrl #(
  parameter int DSP_LAT = 4
) (
  input  logic                clk,
  input  logic                rst,
  fp_mul_iter_ctrl_if.slave   bus,
  output logic [29:0]         dsp_a,
  output logic [17:0]         dsp_b,
  output logic [47:0]         dsp_c,
  output logic [6:0]          dsp_opmode,
  output logic [3:0]          dsp_alumode,
  output logic [4:0]          dsp_inmode,
  input  logic [47:0]         dsp_p
);
  localparam int CW = $clog2(DSP_LAT + 2);
  localparam logic [6:0]    OPM_LO  = 7'b000_0101;  // P = M
  localparam logic [6:0]    OPM_HI  = 7'b110_0101;  // P = (P>>17) + M
  localparam logic [CW-1:0] CYC_LO  = CW'(DSP_LAT - 2);
  localparam logic [CW-1:0] CYC_HI  = CW'(DSP_LAT - 1);
  localparam logic [CW-1:0] CYC_END = CW'(DSP_LAT);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE_LO, S_ISSUE_HI, S_WAIT,
                            S_CAP_LO, S_CAP_HI, S_NORM, S_DONE} state_t;
  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} spc_t;

  state_t        state_q;
  spc_t          spc_q, spc_in;
  logic [CW-1:0] cyc_q;
  logic          sign_q, in_ready_q, out_valid_q;
  logic [7:0]    ea_q, eb_q;
  logic [6:0]    mb_hi_q;
  logic [16:0]   lo17_q;
  logic [30:0]   hi31_q;
  logic [31:0]   result_q, res_d;
  logic [3:0]    flags_q, flg_d;
  logic [29:0]   dsp_a_q;
  logic [17:0]   dsp_b_q;
  logic [6:0]    opmode_q;

  // Operand classification at the acceptance edge
  logic [7:0]  ea_in, eb_in;
  logic [22:0] fa_in, fb_in;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [23:0] ma_in, mb_in;
  assign ea_in  = bus.op_a[30:23];
  assign eb_in  = bus.op_b[30:23];
  assign fa_in  = bus.op_a[22:0];
  assign fb_in  = bus.op_b[22:0];
  assign a_nan  = (&ea_in) & (|fa_in);
  assign b_nan  = (&eb_in) & (|fb_in);
  assign a_inf  = (&ea_in) & ~(|fa_in);
  assign b_inf  = (&eb_in) & ~(|fb_in);
  assign a_zero = (ea_in == 8'd0);
  assign b_zero = (eb_in == 8'd0);
  assign ma_in  = a_zero ? 24'd0 : {1'b1, fa_in};
  assign mb_in  = b_zero ? 24'd0 : {1'b1, fb_in};

  // Special-operand precedence: NaN / inf*0, then inf, then zero
  always_comb begin
    spc_in = SP_NONE;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) spc_in = SP_NAN;
    else if (a_inf || b_inf)                                       spc_in = SP_INF;
    else if (a_zero || b_zero)                                     spc_in = SP_ZERO;
  end

  // Normalise, round and pack the reassembled 48-bit product
  logic [47:0]       m;
  logic [22:0]       mant;
  logic              g, st, inc, inx;
  logic [23:0]       mant_r;
  logic signed [9:0] e_n, e_r;
  always_comb begin
    m    = {hi31_q, lo17_q};
    mant = m[45:23];
    g    = m[22];
    st   = |m[21:0];
    e_n  = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - 10'sd127;
    if (m[47]) begin
      mant = m[46:24];
      g    = m[23];
      st   = |m[22:0];
      e_n  = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - 10'sd126;
    end
`ifdef FPMUL_RNE_EN
    inc = g & (st | mant[0]);
`else
    inc = 1'b0;
`endif
    inx    = g | st;
    mant_r = {1'b0, mant} + {23'd0, inc};
    e_r    = mant_r[23] ? e_n + 10'sd1 : e_n;
    res_d  = {sign_q, e_r[7:0], mant_r[23] ? 23'd0 : mant_r[22:0]};
    flg_d  = {3'b000, inx};
    if (e_r >= 10'sd255) begin
`ifdef FPMUL_RNE_EN
      res_d = {sign_q, 8'hFF, 23'd0};
`else
      res_d = {sign_q, 31'h7F7F_FFFF};
`endif
      flg_d = 4'b0101;
    end else if (e_r <= 10'sd0) begin
      res_d = {sign_q, 31'd0};
      flg_d = {2'b00, 1'b1, inx};
    end
    case (spc_q)
      SP_NAN:  begin res_d = 32'h7FC0_0000;         flg_d = 4'b1000; end
      SP_INF:  begin res_d = {sign_q, 8'hFF, 23'd0}; flg_d = 4'b0000; end
      SP_ZERO: begin res_d = {sign_q, 31'd0};       flg_d = 4'b0000; end
      default: ;
    endcase
  end

  // Control FSM with registered DSP and handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      spc_q       <= SP_NONE;
      cyc_q       <= '0;
      sign_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      ea_q        <= '0;
      eb_q        <= '0;
      mb_hi_q     <= '0;
      lo17_q      <= '0;
      hi31_q      <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      dsp_a_q     <= '0;
      dsp_b_q     <= '0;
      opmode_q    <= '0;
    end else begin
      // OPMODE trails each A/B issue by DSP_LAT-2 cycles (OPMODEREG stage)
      opmode_q <= (cyc_q == CYC_LO) ? OPM_LO : (cyc_q == CYC_HI) ? OPM_HI : 7'd0;
      case (state_q)
        S_IDLE: if (bus.in_valid) begin
          sign_q     <= bus.op_a[31] ^ bus.op_b[31];
          ea_q       <= ea_in;
          eb_q       <= eb_in;
          spc_q      <= spc_in;
          mb_hi_q    <= mb_in[23:17];
          dsp_a_q    <= {6'd0, ma_in};
          dsp_b_q    <= {1'b0, mb_in[16:0]};
          in_ready_q <= 1'b0;
          cyc_q      <= CW'(1);
          state_q    <= S_ISSUE_LO;
        end
        S_ISSUE_LO: begin
          dsp_b_q <= {11'd0, mb_hi_q};
          cyc_q   <= cyc_q + CW'(1);
          state_q <= S_ISSUE_HI;
        end
        S_ISSUE_HI: begin
          dsp_a_q <= '0;
          dsp_b_q <= '0;
          cyc_q   <= cyc_q + CW'(1);
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          cyc_q <= cyc_q + CW'(1);
          if (cyc_q == CYC_END) state_q <= S_CAP_LO;
        end
        S_CAP_LO: begin
          lo17_q  <= dsp_p[16:0];
          state_q <= S_CAP_HI;
        end
        S_CAP_HI: begin
          hi31_q  <= dsp_p[30:0];
          state_q <= S_NORM;
        end
        S_NORM: begin
          result_q    <= res_d;
          flags_q     <= flg_d;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          cyc_q       <= '0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Upper P bits never carry product information (product < 2^48)
  logic unused_p;
  assign unused_p = ^dsp_p[47:31];

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
  assign dsp_a         = dsp_a_q;
  assign dsp_b         = dsp_b_q;
  assign dsp_c         = 48'd0;
  assign dsp_opmode    = opmode_q;
  assign dsp_alumode   = 4'b0000;
  assign dsp_inmode    = 5'b00000;
endmodule

// File: tb/tb_fp_mul_iter_ctrl.sv
// Directed bench for fp_mul_iter_ctrl with a DSP48E1 behavioural model
// (AREG/BREG=2, MREG=1, OPMODEREG=1, PREG=1) and a result scoreboard.
module tb_fp_mul_iter_ctrl;
  localparam int DSP_LAT = 4;
  localparam logic [6:0] OPM_LO = 7'b000_0101;
  localparam logic [6:0] OPM_HI = 7'b110_0101;

`ifdef FPMUL_RNE_EN
  localparam logic [31:0] R_RND   = 32'h4040_0002;
  localparam logic [31:0] R_OVF   = 32'h7F80_0000;
  localparam logic [31:0] R_CARRY = 32'h4000_0000;
`else
  localparam logic [31:0] R_RND   = 32'h4040_0001;
  localparam logic [31:0] R_OVF   = 32'h7F7F_FFFF;
  localparam logic [31:0] R_CARRY = 32'h3FFF_FFFF;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fp_mul_iter_ctrl_if bus();
  logic [29:0] dsp_a;
  logic [17:0] dsp_b;
  logic [47:0] dsp_c;
  logic [6:0]  dsp_opmode;
  logic [3:0]  dsp_alumode;
  logic [4:0]  dsp_inmode;
  logic [47:0] dsp_p;

  fp_mul_iter_ctrl #(.DSP_LAT(DSP_LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_c(dsp_c), .dsp_opmode(dsp_opmode),
    .dsp_alumode(dsp_alumode), .dsp_inmode(dsp_inmode), .dsp_p(dsp_p)
  );

  // DSP48E1 behavioural model
  logic [29:0] a1 = '0, a2 = '0;
  logic [17:0] b1 = '0, b2 = '0;
  logic [47:0] m_r = '0, p_r = '0;
  logic [6:0]  opm_r = '0;
  always @(posedge clk) begin
    a1    <= dsp_a;  a2 <= a1;
    b1    <= dsp_b;  b2 <= b1;
    m_r   <= {18'd0, a2} * {30'd0, b2};
    opm_r <= dsp_opmode;
    case (opm_r)
      OPM_LO:  p_r <= m_r;
      OPM_HI:  p_r <= (p_r >> 17) + m_r;
      default: p_r <= 48'd0;
    endcase
  end
  assign dsp_p = p_r;

  typedef struct packed { logic [31:0] res; logic [3:0] flg; } exp_t;
  exp_t sb[$];
  int nassert = 0;
  int nfail   = 0;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    nassert++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op, push its expectation, wait (bounded) for out_valid and score it
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic [3:0] f, input bit sched);
    int   lat;
    exp_t e;
    bus.op_a = a; bus.op_b = b; bus.in_valid = 1'b1;
    chk("in_ready_at_issue", 48'(bus.in_ready), 48'd1);
    sb.push_back({r, f});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    if (sched) begin
      chk("dsp_a_issue", 48'(dsp_a), {18'd0, 6'd0, 1'b1, a[22:0]});
      chk("dsp_b_lo",    48'(dsp_b), {30'd0, 1'b0, b[16:0]});
    end
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (sched) begin
        if (lat == 2) chk("dsp_b_hi",   48'(dsp_b), {30'd0, 11'd0, 1'b1, b[22:17]});
        if (lat == 3) chk("opmode_lo",  48'(dsp_opmode), {41'd0, OPM_LO});
        if (lat == 4) chk("opmode_hi",  48'(dsp_opmode), {41'd0, OPM_HI});
        if (lat == 5) chk("opmode_off", 48'(dsp_opmode), 48'd0);
      end
    end
    chk("latency", 48'(lat), 48'(DSP_LAT + 4));
    e = sb.pop_front();
    chk("result", 48'(bus.result), 48'(e.res));
    chk("flags",  48'(bus.flags),  48'(e.flg));
    if (bus.out_ready) begin
      @(posedge clk); #1;
      chk("out_valid_after_hs", 48'(bus.out_valid), 48'd0);
      chk("in_ready_after_hs",  48'(bus.in_ready),  48'd1);
    end
  endtask

  initial begin
    int seen;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.op_a = '0; bus.op_b = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  48'(bus.in_ready),  48'd1);
    chk("rst_out_valid", 48'(bus.out_valid), 48'd0);
    chk("rst_result",    48'(bus.result),    48'd0);
    chk("rst_flags",     48'(bus.flags),     48'd0);
    chk("rst_dsp_a",     48'(dsp_a),         48'd0);
    chk("rst_dsp_b",     48'(dsp_b),         48'd0);
    chk("rst_opmode",    48'(dsp_opmode),    48'd0);
    chk("rst_dsp_c",     dsp_c,              48'd0);
    chk("rst_alumode",   48'(dsp_alumode),   48'd0);
    chk("rst_inmode",    48'(dsp_inmode),    48'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic multiply with DSP issue/OPMODE schedule checks
    run_op(32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 1'b1);
    run_op(32'h3F80_0001, 32'h4040_0000, R_RND,         4'b0001, 1'b1);
    run_op(32'h7F00_0000, 32'h7F00_0000, R_OVF,         4'b0101, 1'b0);
    run_op(32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 4'b0010, 1'b0);
    run_op(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000, 1'b0);
    run_op(32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 4'b0000, 1'b0);
    run_op(32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 4'b0000, 1'b0);
    run_op(32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 4'b0000, 1'b0);
    run_op(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000, 1'b0);
    run_op(32'h3FFF_FFFE, 32'h3F80_0001, R_CARRY,       4'b0001, 1'b0);
    run_op(32'h7F7F_FFFF, 32'h3F80_0000, 32'h7F7F_FFFF, 4'b0000, 1'b0);
    run_op(32'h0080_0000, 32'h3F80_0000, 32'h0080_0000, 4'b0000, 1'b0);
    run_op(32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 4'b0010, 1'b0);

    // Backpressure: result held, in_valid pulses ignored until handshake
    bus.out_ready = 1'b0;
    run_op(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.op_a = 32'h4100_0000 + 32'(i);
      bus.op_b = 32'h3F80_0000;
      @(posedge clk); #1;
      chk("bp_result",    48'(bus.result),    48'h0000_4080_0000);
      chk("bp_out_valid", 48'(bus.out_valid), 48'd1);
      chk("bp_in_ready",  48'(bus.in_ready),  48'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_hs_out_valid", 48'(bus.out_valid), 48'd0);
    chk("bp_hs_in_ready",  48'(bus.in_ready),  48'd1);
    run_op(32'h4040_0000, 32'h4040_0000, 32'h4110_0000, 4'b0000, 1'b0);

    // Reset mid-operation in cycle 4
    bus.op_a = 32'h4040_0000; bus.op_b = 32'h4040_0000; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_rst_opmode", 48'(dsp_opmode), {41'd0, OPM_HI});
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 48'(bus.out_valid), 48'd0);
    chk("midrst_opmode",    48'(dsp_opmode),    48'd0);
    chk("midrst_in_ready",  48'(bus.in_ready),  48'd1);
    chk("midrst_dsp_a",     48'(dsp_a),         48'd0);
    chk("midrst_dsp_b",     48'(dsp_b),         48'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    chk("midrst_no_result", 48'(seen), 48'd0);
    run_op(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 4'b0000, 1'b0);

    chk("scoreboard_empty", 48'(sb.size()), 48'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule
